// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding.
`timescale 1ns/1ns
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Combinational full adder: two half adders plus an OR for the carry.
`timescale 1ns/1ns
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a(a),
    .b(b),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .a(s0),
    .b(cin),
    .s(s),
    .c(c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder cell.
`timescale 1ns/1ns
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder cell and a carry flip-flop.
// Optional SERIAL_ADDER_SUB_EN adds a `sub` input for a-b (a + ~b + 1).
`timescale 1ns/1ns
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] sum_shifted;
  logic             fa_s, fa_c;
  logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  full_adder u_fa (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .cin(carry),
    .s(fa_s),
    .cout(fa_c)
  );

  // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  always_comb begin
    sum_shifted = sum >> 1;
    sum_shifted[WIDTH-1] = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            a_sh  <= a;
            // Subtraction: invert b and force carry-in so the adder forms a + ~b + 1.
            b_sh  <= sub_sel ? ~b : b;
            carry <= sub_sel ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          carry <= fa_c;
          sum   <= sum_shifted;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CntLast) begin
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs. arithmetic model.
`timescale 1ns/1ns
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on W+1 bits; subtract is a + (2^W - 1 - b) + 1.
  function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                       input logic tc, input logic ts);
    logic [W:0] r;
    if (SubEn && ts) r = {1'b0, ta} + {1'b0, ~tb_v} + (W+1)'(1);
    else             r = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts);
    int cycles;
    logic [W:0] exp;
    exp = model(ta, tb_v, tc, ts);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tc;  // post-accept changes must be ignored
    check({tag, " busy"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(W));
    check({tag, " sum"}, 32'(sum), 32'(exp[W-1:0]));
    check({tag, " cout"}, 32'(cout), 32'(exp[W]));
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " sum held"}, 32'(sum), 32'(exp[W-1:0]));
  endtask

  initial begin
    int pulses;
    int busy_low;
    logic [W-1:0] ra, rb;
    logic rc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("5a+a5+1", 8'h5A, 8'hA5, 1'b1, 1'b0);
    run_op("12+34", 8'h12, 8'h34, 1'b0, 1'b0);

    // Async reset mid-cycle while idle with a non-zero result.
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("async rst sum", 32'(sum), 32'd0);
    check("async rst cout", 32'(cout), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;

    // start held high through RUN with a changing: exactly one done pulse.
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF;
    pulses = 0; busy_low = 0;
    for (int i = 0; i < W; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (!busy && !done) busy_low++;
    end
    start = 1'b0;
    check("held start done pulses", 32'(pulses), 32'd1);
    check("held start busy", 32'(busy_low), 32'd0);
    check("held start sum", 32'(sum), 32'h4B);
    check("held start cout", 32'(cout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("held start no restart", 32'(pulses), 32'd1);

    // Reset during the third RUN cycle aborts without done.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run_op("after abort 12+34", 8'h12, 8'h34, 1'b0, 1'b0);

    if (SubEn) begin
      run_op("10-01", 8'h10, 8'h01, 1'b0, 1'b1);
      run_op("01-02", 8'h01, 8'h02, 1'b1, 1'b1);
    end

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, rc, SubEn ? 1'($urandom) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
